// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator PUF readout: FSM states,
// settle length and default parameter values.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        COMPARE,
        DONE
    } puf_state_t;

    localparam int SETTLE_LEN = 4;

    localparam int DEF_NUM_RO     = 16;
    localparam int DEF_RESP_BITS  = 8;
    localparam int DEF_WIN_CYCLES = 256;
    localparam int DEF_CNT_W      = 12;
    localparam int DEF_VOTES      = 3;

endpackage

// File: rtl/puf_edge_counter.sv
// Counts rising edges of one asynchronous oscillator after a 2-flop
// synchronizer; saturates instead of wrapping.
module puf_edge_counter
    import puf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             ro,
    output logic [CNT_W-1:0] count
);

    // sync[1:0] form the synchronizer, sync[2] holds the previous synced value
    logic [2:0] sync;
    logic       rise;

    assign rise = sync[1] & ~sync[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            count <= '0;
        end else begin
            sync <= {sync[1:0], ro};
            if (clear) begin
                count <= '0;
            end else if (enable && rise && (count != '1)) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/puf_ro_readout.sv
// Ring-oscillator PUF readout: compares edge counts of oscillator pairs over
// a fixed window, majority-votes each response bit and flags unstable bits.
module puf_ro_readout
    import puf_pkg::*;
#(
    parameter int NUM_RO     = DEF_NUM_RO,
    parameter int RESP_BITS  = DEF_RESP_BITS,
    parameter int WIN_CYCLES = DEF_WIN_CYCLES,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int VOTES      = DEF_VOTES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(NUM_RO)-1:0] addr,
    input  logic [NUM_RO-1:0]         ro_in,
    output logic [NUM_RO-1:0]         ro_en,
    output logic                      busy,
    output logic                      done,
    output logic [RESP_BITS-1:0]      resp,
    output logic [RESP_BITS-1:0]      unstable
);

    localparam int AW = $clog2(NUM_RO);
    localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int VW = $clog2(VOTES + 1);
    localparam int WW = $clog2(WIN_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_LEN);

    puf_state_t           state;
    logic [AW-1:0]        addr_q;
    logic [BW-1:0]        bit_idx;
    logic [VW-1:0]        vote_idx;
    logic [VW-1:0]        ones;
    logic                 tie_seen;
    logic [SW-1:0]        phase;
    logic [WW-1:0]        win_cnt;
    logic [RESP_BITS-1:0] resp_work;
    logic [RESP_BITS-1:0] unst_work;

    logic [AW-1:0]        idx_a;
    logic [AW-1:0]        idx_b;
    logic [CNT_W-1:0]     cnt_a;
    logic [CNT_W-1:0]     cnt_b;
    logic                 cnt_clear;
    logic                 cnt_enable;

    logic                 vote;
    logic                 tie;
    logic [VW-1:0]        ones_nxt;
    logic                 tie_nxt;
    logic                 bit_val;
    logic                 bit_unst;
    logic [RESP_BITS-1:0] bit_mask;
    logic [RESP_BITS-1:0] resp_nxt;
    logic [RESP_BITS-1:0] unst_nxt;
    logic                 last_vote;
    logic                 last_bit;

    function automatic logic [NUM_RO-1:0] pair_mask(input int base_addr, input int bit_no);
        int            base;
        logic [AW-1:0] ia;
        logic [AW-1:0] ib;
        base      = base_addr + 2 * bit_no;
        ia        = AW'(base % NUM_RO);
        ib        = AW'((base + 1) % NUM_RO);
        pair_mask = '0;
        pair_mask[ia] = 1'b1;
        pair_mask[ib] = 1'b1;
    endfunction

    // Oscillator pair selection wraps modulo NUM_RO
    always_comb begin
        int sum_a;
        sum_a = int'(addr_q) + 2 * int'(bit_idx);
        idx_a = AW'(sum_a % NUM_RO);
        idx_b = AW'((sum_a + 1) % NUM_RO);
    end

    assign cnt_clear  = (state == SETTLE);
    assign cnt_enable = (state == COUNT);

    puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .ro     (ro_in[idx_a]),
        .count  (cnt_a)
    );

    puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .ro     (ro_in[idx_b]),
        .count  (cnt_b)
    );

    // Vote for the current measurement folded into the running bit tally
    always_comb begin
        vote      = (cnt_a > cnt_b);
        tie       = (cnt_a == cnt_b);
        ones_nxt  = ones + VW'(vote);
        tie_nxt   = tie_seen | tie;
        bit_val   = (ones_nxt > VW'(VOTES / 2));
        bit_unst  = tie_nxt | ((ones_nxt != '0) && (ones_nxt != VW'(VOTES)));
        bit_mask  = RESP_BITS'(1) << bit_idx;
        resp_nxt  = (resp_work & ~bit_mask) | (bit_val  ? bit_mask : '0);
        unst_nxt  = (unst_work & ~bit_mask) | (bit_unst ? bit_mask : '0);
        last_vote = (vote_idx == VW'(VOTES - 1));
        last_bit  = (bit_idx == BW'(RESP_BITS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            bit_idx   <= '0;
            vote_idx  <= '0;
            ones      <= '0;
            tie_seen  <= 1'b0;
            phase     <= '0;
            win_cnt   <= '0;
            resp_work <= '0;
            unst_work <= '0;
            resp      <= '0;
            unstable  <= '0;
            ro_en     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q    <= addr;
                        bit_idx   <= '0;
                        vote_idx  <= '0;
                        ones      <= '0;
                        tie_seen  <= 1'b0;
                        phase     <= '0;
                        resp_work <= '0;
                        unst_work <= '0;
                        ro_en     <= pair_mask(int'(addr), 0);
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (phase == SW'(SETTLE_LEN - 1)) begin
                        phase   <= '0;
                        win_cnt <= '0;
                        state   <= COUNT;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                COUNT: begin
                    if (win_cnt == WW'(WIN_CYCLES - 1)) begin
                        ro_en <= '0;
                        state <= COMPARE;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                COMPARE: begin
                    state <= SETTLE;
                    if (!last_vote) begin
                        vote_idx <= vote_idx + 1'b1;
                        ones     <= ones_nxt;
                        tie_seen <= tie_nxt;
                        ro_en    <= pair_mask(int'(addr_q), int'(bit_idx));
                    end else begin
                        resp_work <= resp_nxt;
                        unst_work <= unst_nxt;
                        vote_idx  <= '0;
                        ones      <= '0;
                        tie_seen  <= 1'b0;
                        if (!last_bit) begin
                            bit_idx <= bit_idx + 1'b1;
                            ro_en   <= pair_mask(int'(addr_q), int'(bit_idx) + 1);
                        end else begin
                            resp     <= resp_nxt;
                            unstable <= unst_nxt;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_ro_readout.sv
// Directed bench for puf_ro_readout: oscillators are modelled as clk-derived
// square waves with per-input periods; a second instance covers saturation.
module tb_puf_ro_readout;

    localparam int N  = 8 * 3 * (256 + 5);
    localparam int N2 = 1 * 1 * (256 + 5);

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  addr;
    logic [15:0] ro_in;
    logic [15:0] ro_en;
    logic        busy;
    logic        done;
    logic [7:0]  resp;
    logic [7:0]  unstable;

    logic        start2;
    logic [1:0]  addr2;
    logic [3:0]  ro_in2;
    logic [3:0]  ro_en2;
    logic        busy2;
    logic        done2;
    logic [0:0]  resp2;
    logic [0:0]  unstable2;

    int per[16]  = '{default: 6};
    int per2[4]  = '{default: 4};
    int tick     = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int done_seen;

    always #5 clk = ~clk;

    puf_ro_readout dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .addr     (addr),
        .ro_in    (ro_in),
        .ro_en    (ro_en),
        .busy     (busy),
        .done     (done),
        .resp     (resp),
        .unstable (unstable)
    );

    puf_ro_readout #(
        .NUM_RO     (4),
        .RESP_BITS  (1),
        .WIN_CYCLES (256),
        .CNT_W      (4),
        .VOTES      (1)
    ) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .addr     (addr2),
        .ro_in    (ro_in2),
        .ro_en    (ro_en2),
        .busy     (busy2),
        .done     (done2),
        .resp     (resp2),
        .unstable (unstable2)
    );

    // Oscillators change on the falling edge, all in phase at equal periods
    always @(negedge clk) begin
        tick = tick + 1;
        for (int k = 0; k < 16; k++) ro_in[k]  = ((tick % per[k])  < (per[k] / 2));
        for (int k = 0; k < 4; k++)  ro_in2[k] = ((tick % per2[k]) < (per2[k] / 2));
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a);
        @(negedge clk);
        addr  = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        addr   = '0;
        addr2  = '0;
        waitCycles(3);
        checkOutput("reset_resp",     32'(resp),     32'h0);
        checkOutput("reset_unstable", 32'(unstable), 32'h0);
        checkOutput("reset_done",     32'(done),     32'h0);
        checkOutput("reset_busy",     32'(busy),     32'h0);
        checkOutput("reset_ro_en",    32'(ro_en),    32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] basic pair 0 vs 1");
        per[0] = 4;
        per[1] = 8;
        applyStimulus(4'd0);
        checkOutput("a_busy_settle",  32'(busy),  32'h1);
        checkOutput("a_ro_en_settle", 32'(ro_en), 32'h0003);
        waitCycles(100);
        start = 1'b1;
        addr  = 4'd5;
        waitCycles(1);
        start = 1'b0;
        addr  = 4'd0;
        waitCycles(159);
        checkOutput("a_ro_en_compare", 32'(ro_en), 32'h0);
        checkOutput("a_busy_compare",  32'(busy),  32'h1);
        waitCycles(1);
        checkOutput("a_ro_en_vote2", 32'(ro_en), 32'h0003);
        waitCycles(522);
        checkOutput("a_ro_en_bit1", 32'(ro_en), 32'h000C);
        waitCycles(N - 1 - 783);
        checkOutput("a_done_early", 32'(done), 32'h0);
        waitCycles(1);
        checkOutput("a_done",     32'(done),     32'h1);
        checkOutput("a_busy_done", 32'(busy),    32'h1);
        checkOutput("a_resp",     32'(resp),     32'h01);
        checkOutput("a_unstable", 32'(unstable), 32'hFE);
        waitCycles(1);
        checkOutput("a_done_after", 32'(done), 32'h0);
        checkOutput("a_busy_after", 32'(busy), 32'h0);
        checkOutput("a_resp_held",  32'(resp), 32'h01);

        $display("[TB] wrapped pair 15 vs 0");
        per[0]  = 4;
        per[1]  = 6;
        per[15] = 8;
        applyStimulus(4'd15);
        checkOutput("b_ro_en_wrap", 32'(ro_en), 32'h8001);
        waitCycles(N - 1);
        checkOutput("b_done_early", 32'(done), 32'h0);
        waitCycles(1);
        checkOutput("b_done",     32'(done),     32'h1);
        checkOutput("b_resp",     32'(resp),     32'h00);
        checkOutput("b_unstable", 32'(unstable), 32'hFE);
        waitCycles(1);

        $display("[TB] split vote on pair 2 vs 3");
        per[15] = 6;
        per[0]  = 4;
        per[1]  = 8;
        per[2]  = 4;
        per[3]  = 8;
        applyStimulus(4'd0);
        waitCycles(1046);
        per[2] = 8;
        per[3] = 4;
        waitCycles(261);
        per[2] = 4;
        per[3] = 8;
        waitCycles(N - 1 - 1307);
        checkOutput("c_done_early", 32'(done), 32'h0);
        waitCycles(1);
        checkOutput("c_done",     32'(done),     32'h1);
        checkOutput("c_resp",     32'(resp),     32'h03);
        checkOutput("c_unstable", 32'(unstable), 32'hFE);
        waitCycles(1);

        $display("[TB] identical oscillators");
        for (int k = 0; k < 16; k++) per[k] = 4;
        applyStimulus(4'd3);
        waitCycles(N);
        checkOutput("d_done",     32'(done),     32'h1);
        checkOutput("d_resp",     32'(resp),     32'h00);
        checkOutput("d_unstable", 32'(unstable), 32'hFF);
        waitCycles(1);

        $display("[TB] reset mid-challenge");
        per[0] = 4;
        per[1] = 8;
        applyStimulus(4'd0);
        waitCycles(999);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        checkOutput("e_busy",     32'(busy),     32'h0);
        checkOutput("e_ro_en",    32'(ro_en),    32'h0);
        checkOutput("e_resp",     32'(resp),     32'h0);
        checkOutput("e_unstable", 32'(unstable), 32'h0);
        done_seen = 0;
        for (int i = 0; i < 5400; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checkOutput("e_no_done",    32'(done_seen), 32'h0);
        checkOutput("e_resp_after", 32'(resp),      32'h0);

        $display("[TB] saturating counters");
        per2[0] = 2;
        per2[1] = 4;
        @(negedge clk);
        addr2  = 2'd0;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        checkOutput("f_ro_en", 32'(ro_en2), 32'h3);
        waitCycles(N2 - 1);
        checkOutput("f_done_early", 32'(done2), 32'h0);
        waitCycles(1);
        checkOutput("f_done",     32'(done2),     32'h1);
        checkOutput("f_resp",     32'(resp2),     32'h0);
        checkOutput("f_unstable", 32'(unstable2), 32'h1);
        waitCycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_ro_readout.md
PUF_RO_READOUT -- requirements
Module: puf_ro_readout

Interface
REQ-001 The block SHALL have parameter NUM_RO, default 16: number of ring-oscillator inputs; even, at least 4.
REQ-002 The block SHALL have parameter RESP_BITS, default 8: response bits produced per challenge.
REQ-003 The block SHALL have parameter WIN_CYCLES, default 256: count window in clk cycles.
REQ-004 The block SHALL have parameter CNT_W, default 12: width of each edge counter.
REQ-005 The block SHALL have parameter VOTES, default 3: measurements per bit; odd, at least 1.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 The block SHALL have port clk, input, 1: sole clock.
REQ-008 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 The block SHALL have port start, input, 1: begin a challenge; sampled only in IDLE.
REQ-010 The block SHALL have port addr, input, clog2(NUM_RO): challenge base index; latched on an accepted start.
REQ-011 The block SHALL have port ro_in, input, NUM_RO: asynchronous oscillator outputs.
REQ-012 The block SHALL have port ro_en, output, NUM_RO: oscillator enables; one-hot pair enable only during SETTLE/COUNT.
REQ-013 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1: one-cycle pulse when the response is valid.
REQ-015 The block SHALL have port resp, output, RESP_BITS: registered response, held until the next done or reset.
REQ-016 The block SHALL have port unstable, output, RESP_BITS: per-bit flag, set when votes were not unanimous or a tie occurred.

Function
REQ-017 The FSM SHALL have states IDLE, SETTLE, COUNT, COMPARE and DONE.
REQ-018 In IDLE, start=1 SHALL latch addr, clear the bit/vote indices, and enter SETTLE on the next cycle.
REQ-019 start SHALL be ignored while busy=1; start held high across DONE SHALL launch a new challenge.
REQ-020 For bit i, pair A SHALL be (addr+2i) mod NUM_RO and pair B SHALL be (addr+2i+1) mod NUM_RO; the index SHALL wrap around.
REQ-021 SETTLE SHALL last 4 cycles: the pair A/B ro_en bits high, all other ro_en bits low, counters held at 0, synchronizers flushing.
REQ-022 COUNT SHALL last exactly WIN_CYCLES cycles; each counter SHALL increment on every rising edge of its 2-flop-synchronized input.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 COMPARE SHALL last 1 cycle with ro_en all 0: vote = (cntA > cntB); cntA == cntB SHALL give vote 0 and set the tie flag for that bit.
REQ-025 After COMPARE: if votes remain for bit i, the FSM SHALL go to SETTLE (same pair); else if bits remain, it SHALL go to SETTLE with i+1; else it SHALL go to DONE.
REQ-026 Bit value SHALL be the majority of its VOTES votes; unstable[i] SHALL be set if votes are not unanimous or any tie occurred.
REQ-027 Entering DONE SHALL register resp and unstable together; done=1 and busy=1 for that single cycle, then IDLE.
REQ-028 Latency: with N = RESP_BITS*VOTES*(WIN_CYCLES+5), done SHALL be high N+1 cycles after the edge sampling start (defaults: N=6264).
REQ-029 resp and unstable SHALL NOT change outside the DONE cycle or reset.

Reset
REQ-030 reset=1 at any clk edge, including mid-challenge, SHALL force IDLE on the next cycle.
REQ-031 Reset values SHALL be: resp=0, unstable=0, done=0, busy=0, ro_en=0, counters=0, synchronizers=0, indices=0.
REQ-032 A challenge interrupted by reset SHALL produce no done pulse and leave resp at 0.

Structure
REQ-033 A shared package puf_pkg SHALL hold the FSM state enum, the SETTLE length constant (4) and the default parameter values.
REQ-034 Sub-module puf_edge_counter SHALL contain sync, rising-edge detect, clear/enable and a saturating counter, with parameter CNT_W; it SHALL be instantiated twice (A, B).
REQ-035 The oscillator mux SHALL be combinational from the latched addr and bit index; no other clocks.

Verification
REQ-036 Defaults, addr=0, ro_in[0] period 4, ro_in[1] period 8, others period 6 -> resp[0]=1, unstable[0]=0, done exactly at cycle 6265.
REQ-037 addr=15, ro_in[15] period 8, ro_in[0] period 4 -> bit 0 pairs 15 vs 0 (wrap); resp[0]=0.
REQ-038 All ro_in identical period 4 -> resp=0x00, unstable=0xFF.
REQ-039 ro_in[2] faster than ro_in[3] in votes 1 and 3, slower in vote 2 -> resp[1]=1, unstable[1]=1.
REQ-040 reset asserted at cycle 1000 of a challenge -> busy=0 and ro_en=0 next cycle; no done pulse; resp=0.
REQ-041 CNT_W=4, WIN_CYCLES=256, pair A period 2, pair B period 4 -> both counters saturate at 15; tie, vote 0, unstable set.
